// File: rtl/bus_xfer_pkg.sv
// Shared encodings for the register-transfer sequencer: command ops, FSM states
// and the default bank geometry.
package bus_xfer_pkg;

  localparam int NREG_DEF = 16;
  localparam int IDXW_DEF = 4;
  localparam int DW_DEF   = 32;
  localparam int TMP_DEF  = NREG_DEF - 1;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_MOVE  = 2'b01,
    OP_LOADI = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    X1   = 2'b01,
    X2   = 2'b10,
    X3   = 2'b11
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie
// and flips to the loser of each accepted handshake.
module rr_arb2 (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o,
  output logic       ptr_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) ptr_d = grant_o[0];
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bus_xfer_seq.sv
// Bus transfer sequencer: arbitrates two command sources and drives registered
// one-hot bus-source selects and register load enables for MOVE, LOADI and SWAP.
module bus_xfer_seq
  import bus_xfer_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int IDXW = IDXW_DEF,
  parameter int DW   = DW_DEF,
  parameter int TMP  = NREG - 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req0_op,
  input  logic [1:0]      req1_op,
  input  logic [IDXW-1:0] req0_src,
  input  logic [IDXW-1:0] req1_src,
  input  logic [IDXW-1:0] req0_dst,
  input  logic [IDXW-1:0] req1_dst,
  input  logic [DW-1:0]   req0_imm,
  input  logic [DW-1:0]   req1_imm,
  output logic [NREG-1:0] bus_src_sel,
  output logic            imm_drive,
  output logic [DW-1:0]   imm_bus,
  output logic [NREG-1:0] reg_load,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [IDXW-1:0] TmpIdx = IDXW'(TMP);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [IDXW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [NREG-1:0]   sel_q, sel_d, load_q, load_d;
  logic              drv_q, drv_d;
  logic [DW-1:0]     imm_q, imm_d;
  logic              done_q, done_d, err_q, err_d;

  logic [1:0]        grant;
  logic              arb_ptr;
  logic              hs;
  logic              pick;
  op_e               cmd_op;
  logic [IDXW-1:0]   cmd_src, cmd_dst;
  logic [DW-1:0]     cmd_imm;
  logic              swap_bad;

  function automatic logic [NREG-1:0] dec(input logic [IDXW-1:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  rr_arb2 u_arb (
    .clk      (clk),
    .clr      (clr),
    .valid_i  (req_valid),
    .accept_i (hs),
    .grant_o  (grant),
    .ptr_o    (arb_ptr)
  );

  // Ready is offered only from IDLE and is forced low while reset is asserted.
  assign req_ready = (clr && state_q == IDLE) ? grant : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign pick      = (req_valid == 2'b11) ? arb_ptr : req_valid[1];

  assign cmd_op   = op_e'(pick ? req1_op : req0_op);
  assign cmd_src  = pick ? req1_src : req0_src;
  assign cmd_dst  = pick ? req1_dst : req0_dst;
  assign cmd_imm  = pick ? req1_imm : req0_imm;
  assign swap_bad = (cmd_src == cmd_dst) || (cmd_src == TmpIdx) || (cmd_dst == TmpIdx);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    sel_d   = '0;
    load_d  = '0;
    drv_d   = 1'b0;
    imm_d   = imm_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          op_d  = cmd_op;
          src_d = cmd_src;
          dst_d = cmd_dst;
          unique case (cmd_op)
            OP_NOP: done_d = 1'b1;
            OP_MOVE: begin
              state_d = X1;
              sel_d   = dec(cmd_src);
              load_d  = dec(cmd_dst);
            end
            OP_LOADI: begin
              state_d = X1;
              drv_d   = 1'b1;
              imm_d   = cmd_imm;
              load_d  = dec(cmd_dst);
            end
            OP_SWAP: begin
              if (swap_bad) begin
                err_d = 1'b1;
              end else begin
                state_d = X1;
                sel_d   = dec(cmd_src);
                load_d  = dec(TmpIdx);
              end
            end
            default: ;
          endcase
        end
      end
      X1: begin
        if (op_q == OP_SWAP) begin
          state_d = X2;
          sel_d   = dec(dst_q);
          load_d  = dec(src_q);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      X2: begin
        state_d = X3;
        sel_d   = dec(TmpIdx);
        load_d  = dec(dst_q);
      end
      X3: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      src_q   <= '0;
      dst_q   <= '0;
      sel_q   <= '0;
      load_q  <= '0;
      drv_q   <= 1'b0;
      imm_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      drv_q   <= drv_d;
      imm_q   <= imm_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus_src_sel = sel_q;
  assign reg_load    = load_q;
  assign imm_drive   = drv_q;
  assign imm_bus     = imm_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq with a behavioural register bank on the bus.
module tb_bus_xfer_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req0_op, req1_op;
  logic [3:0]  req0_src, req1_src, req0_dst, req1_dst;
  logic [31:0] req0_imm, req1_imm;
  logic [15:0] bus_src_sel, reg_load;
  logic        imm_drive;
  logic [31:0] imm_bus;
  logic        busy, done, err;

  int tests = 0;
  int fails = 0;

  logic [31:0] regs [16];

  typedef struct {
    int          req;
    logic [1:0]  op;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [31:0] imm;
    logic [15:0] eSel;
    logic [15:0] eLoad;
    logic        eDrv;
    logic        eBusy;
    logic        eDone1;
    logic        eErr1;
    logic        eDone2;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  bus_xfer_seq dut (
    .clk         (clk),
    .clr         (clr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_op     (req0_op),
    .req1_op     (req1_op),
    .req0_src    (req0_src),
    .req1_src    (req1_src),
    .req0_dst    (req0_dst),
    .req1_dst    (req1_dst),
    .req0_imm    (req0_imm),
    .req1_imm    (req1_imm),
    .bus_src_sel (bus_src_sel),
    .imm_drive   (imm_drive),
    .imm_bus     (imm_bus),
    .reg_load    (reg_load),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Register bank model: whatever the selects put on the bus is captured by the loaded register.
  always @(posedge clk) begin
    logic [31:0] busVal;
    if (clr) begin
      busVal = imm_drive ? imm_bus : 32'h0;
      for (int i = 0; i < 16; i++) if (bus_src_sel[i]) busVal = regs[i];
      for (int i = 0; i < 16; i++) if (reg_load[i]) regs[i] <= busVal;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int req, input logic [1:0] op, input logic [3:0] src,
                               input logic [3:0] dst, input logic [31:0] imm, output bit ok);
    int waits;
    @(negedge clk);
    if (req == 0) begin
      req0_op = op; req0_src = src; req0_dst = dst; req0_imm = imm;
      req_valid = 2'b01;
    end else begin
      req1_op = op; req1_src = src; req1_dst = dst; req1_imm = imm;
      req_valid = 2'b10;
    end
    #1;
    waits = 0;
    while (!req_ready[req] && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    checkOutput($sformatf("handshake ready r%0d", req), 32'(req_ready[req]), 32'd1);
    ok = req_ready[req];
    if (!ok) begin
      req_valid = 2'b00;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    logic [1:0] expReady;

    for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + i;

    vecs[0] = '{0, 2'b01, 4'd3,  4'd5,  32'd0,  16'h0008, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1, 2'b10, 4'd0,  4'd2,  32'd50, 16'h0000, 16'h0004, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{0, 2'b10, 4'd0,  4'd1,  32'd20, 16'h0000, 16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{1, 2'b10, 4'd0,  4'd4,  32'd30, 16'h0000, 16'h0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{0, 2'b01, 4'd6,  4'd6,  32'd0,  16'h0040, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{0, 2'b11, 4'd7,  4'd15, 32'd0,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1, 2'b11, 4'd15, 4'd3,  32'd0,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{0, 2'b11, 4'd9,  4'd9,  32'd0,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1, 2'b00, 4'd0,  4'd0,  32'd0,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{0, 2'b01, 4'd0,  4'd14, 32'd0,  16'h0001, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset held with random request traffic: everything quiet, nothing offered.
    clr = 1'b0;
    req_valid = 2'b00;
    req0_op = 2'b00; req1_op = 2'b00;
    req0_src = 4'd0; req1_src = 4'd0; req0_dst = 4'd0; req1_dst = 4'd0;
    req0_imm = 32'd0; req1_imm = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 2'($urandom_range(0, 3));
      req0_op = 2'($urandom); req1_op = 2'($urandom);
      req0_src = 4'($urandom); req1_dst = 4'($urandom);
      req0_imm = $urandom; req1_imm = $urandom;
    end
    #1;
    checkOutput("reset sel",   32'(bus_src_sel), 32'h0);
    checkOutput("reset load",  32'(reg_load),    32'h0);
    checkOutput("reset drv",   32'(imm_drive),   32'h0);
    checkOutput("reset imm",   imm_bus,          32'h0);
    checkOutput("reset busy",  32'(busy),        32'h0);
    checkOutput("reset done",  32'(done),        32'h0);
    checkOutput("reset err",   32'(err),         32'h0);
    checkOutput("reset ready", 32'(req_ready),   32'h0);

    // Release with both requesting NOPs: grants alternate starting with requester 0.
    @(negedge clk);
    clr = 1'b1;
    req_valid = 2'b11;
    req0_op = 2'b00; req1_op = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      expReady = (k % 2 == 0) ? 2'b01 : 2'b10;
      checkOutput($sformatf("rr grant %0d", k), 32'(req_ready), 32'(expReady));
      @(negedge clk);
    end
    req_valid = 2'b00;

    // Single-command vectors: first cycle after handshake, then the cycle after.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].req, vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].imm, ok);
      if (ok) begin
        checkOutput($sformatf("v%0d sel", i),  32'(bus_src_sel), 32'(vecs[i].eSel));
        checkOutput($sformatf("v%0d load", i), 32'(reg_load),    32'(vecs[i].eLoad));
        checkOutput($sformatf("v%0d drv", i),  32'(imm_drive),   32'(vecs[i].eDrv));
        checkOutput($sformatf("v%0d busy", i), 32'(busy),        32'(vecs[i].eBusy));
        checkOutput($sformatf("v%0d done", i), 32'(done),        32'(vecs[i].eDone1));
        checkOutput($sformatf("v%0d err", i),  32'(err),         32'(vecs[i].eErr1));
        if (vecs[i].eDrv) checkOutput($sformatf("v%0d imm", i), imm_bus, vecs[i].imm);
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d done2", i), 32'(done),      32'(vecs[i].eDone2));
        checkOutput($sformatf("v%0d load2", i), 32'(reg_load),  32'h0);
        checkOutput($sformatf("v%0d drv2", i),  32'(imm_drive), 32'h0);
        checkOutput($sformatf("v%0d busy2", i), 32'(busy),      32'h0);
        checkOutput($sformatf("v%0d err2", i),  32'(err),       32'h0);
      end
    end

    @(negedge clk);
    checkOutput("R5 after move",   regs[5],  32'h1003);
    checkOutput("R2 after loadi",  regs[2],  32'd50);
    checkOutput("R1 after loadi",  regs[1],  32'd20);
    checkOutput("R4 after loadi",  regs[4],  32'd30);
    checkOutput("R6 self move",    regs[6],  32'h1006);
    checkOutput("R14 after move",  regs[14], 32'h1000);
    checkOutput("R7 rejected",     regs[7],  32'h1007);
    checkOutput("R15 rejected",    regs[15], 32'h100f);

    // SWAP R1<->R4 through R15.
    applyStimulus(0, 2'b11, 4'd1, 4'd4, 32'd0, ok);
    if (ok) begin
      checkOutput("swap x1 sel",  32'(bus_src_sel), 32'h0002);
      checkOutput("swap x1 load", 32'(reg_load),    32'h8000);
      checkOutput("swap x1 busy", 32'(busy),        32'h1);
      @(posedge clk); #1;
      checkOutput("swap x2 sel",  32'(bus_src_sel), 32'h0010);
      checkOutput("swap x2 load", 32'(reg_load),    32'h0002);
      checkOutput("swap x2 done", 32'(done),        32'h0);
      @(posedge clk); #1;
      checkOutput("swap x3 sel",  32'(bus_src_sel), 32'h8000);
      checkOutput("swap x3 load", 32'(reg_load),    32'h0010);
      @(posedge clk); #1;
      checkOutput("swap done",    32'(done),        32'h1);
      checkOutput("swap end load", 32'(reg_load),   32'h0);
      checkOutput("swap end busy", 32'(busy),       32'h0);
      @(negedge clk);
      checkOutput("swap R1",  regs[1],  32'd30);
      checkOutput("swap R4",  regs[4],  32'd20);
      checkOutput("swap R15", regs[15], 32'd20);
    end

    // Reset dropped during X2 of a SWAP R2<->R5: outputs clear at once, no completion.
    applyStimulus(1, 2'b11, 4'd2, 4'd5, 32'd0, ok);
    if (ok) begin
      checkOutput("midrst x1 load", 32'(reg_load), 32'h8000);
      @(posedge clk); #1;
      checkOutput("midrst x2 load", 32'(reg_load), 32'h0004);
      #2;
      clr = 1'b0;
      #1;
      checkOutput("midrst sel",  32'(bus_src_sel), 32'h0);
      checkOutput("midrst load", 32'(reg_load),    32'h0);
      checkOutput("midrst busy", 32'(busy),        32'h0);
      checkOutput("midrst done", 32'(done),        32'h0);
      @(negedge clk);
      @(negedge clk);
      clr = 1'b1;
      #1;
      checkOutput("midrst rel done", 32'(done), 32'h0);
      checkOutput("midrst rel err",  32'(err),  32'h0);
      @(posedge clk); #1;
      checkOutput("midrst post done", 32'(done), 32'h0);
      checkOutput("midrst post busy", 32'(busy), 32'h0);
    end

    applyStimulus(0, 2'b01, 4'd5, 4'd7, 32'd0, ok);
    if (ok) begin
      checkOutput("post move sel",  32'(bus_src_sel), 32'h0020);
      checkOutput("post move load", 32'(reg_load),    32'h0080);
      @(posedge clk); #1;
      checkOutput("post move done", 32'(done), 32'h1);
      @(negedge clk);
      checkOutput("post R7",  regs[7],  32'h1003);
      checkOutput("post R5",  regs[5],  32'h1003);
      checkOutput("post R2",  regs[2],  32'd50);
      checkOutput("post R15", regs[15], 32'd50);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
